// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with frame tracking, idle gap and start timeout
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int GAP      = 0,
    parameter int START_TO = 4,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              reset,
    input  logic              BRclk,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data_in,
    output logic [NREQ-1:0]   ack,
    output logic              TX_EN,
    output logic [7:0]        TX_DATA,
    input  logic              TX_STATUS,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP_WAIT} state_t;
    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d, grant_q, grant_d, win;
    logic [7:0]        data_q, data_d, gap_q, gap_d;
    logic [3:0]        to_q, to_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              en_q, en_d, err_q, err_d, found;
    int                idx;

    // Round-robin search: first pending requester after the last winner, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    // Next-state logic; ack and TX_EN are computed one cycle early so they are registered and high only in LAUNCH
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        gap_d   = gap_q;
        to_d    = to_q;
        ack_d   = '0;
        en_d    = 1'b0;
        err_d   = err_clr ? 1'b0 : err_q;
        case (state_q)
            IDLE: if (found && !TX_STATUS) begin
                state_d    = LAUNCH;
                ptr_d      = win;
                grant_d    = win;
                data_d     = data_in[8*int'(win) +: 8];
                ack_d[win] = 1'b1;
                en_d       = 1'b1;
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
                to_d    = '0;
            end
            WAIT_BUSY: if (TX_STATUS) state_d = WAIT_DONE;
            else begin
                to_d = to_q + 4'd1;
                if (to_d == 4'(START_TO)) begin
                    err_d   = 1'b1;
                    gap_d   = 8'(GAP);
                    state_d = GAP_WAIT;
                end
            end
            WAIT_DONE: if (!TX_STATUS) begin
                gap_d   = 8'(GAP);
                state_d = (GAP > 0) ? GAP_WAIT : IDLE;
            end
            GAP_WAIT: begin
                gap_d = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
                if (gap_q <= 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset puts the pointer at NREQ-1 so requester 0 wins first
    always_ff @(posedge BRclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= GW'(NREQ - 1);
            grant_q <= '0;
            data_q  <= 8'h00;
            gap_q   <= 8'd0;
            to_q    <= 4'd0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign ack      = ack_q;
    assign TX_EN    = en_q;
    assign TX_DATA  = data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural transmitter, one GAP=0 and one GAP=20 instance
module tb_uart_tx_arbiter;
    logic BRclk = 1'b0;
    logic reset = 1'b1;
    always #5 BRclk = ~BRclk;

    logic [3:0]  req [2];
    logic [31:0] din [2];
    logic [3:0]  ack [2];
    logic        tx_en [2];
    logic [7:0]  txd [2];
    logic [1:0]  gid [2];
    logic        busy [2];
    logic        err [2];
    logic        clr [2];
    logic        sts [2];
    logic        st_in [2];
    bit          stub [2];
    bit          force_busy [2];
    int          cnt [2];
    logic [7:0]  shreg [2];

    assign st_in[0] = sts[0] | force_busy[0];
    assign st_in[1] = sts[1] | force_busy[1];

    uart_tx_arbiter #(.NREQ(4), .GAP(0), .START_TO(4)) u0 (
        .reset(reset), .BRclk(BRclk), .req(req[0]), .data_in(din[0]), .ack(ack[0]),
        .TX_EN(tx_en[0]), .TX_DATA(txd[0]), .TX_STATUS(st_in[0]), .grant_id(gid[0]),
        .busy(busy[0]), .err(err[0]), .err_clr(clr[0]));

    uart_tx_arbiter #(.NREQ(4), .GAP(20), .START_TO(4)) u1 (
        .reset(reset), .BRclk(BRclk), .req(req[1]), .data_in(din[1]), .ack(ack[1]),
        .TX_EN(tx_en[1]), .TX_DATA(txd[1]), .TX_STATUS(st_in[1]), .grant_id(gid[1]),
        .busy(busy[1]), .err(err[1]), .err_clr(clr[1]));

    // Transmitter model: busy the cycle after TX_EN for 160 cycles; a stubbed transmitter never starts
    always @(posedge BRclk or posedge reset)
        for (int g = 0; g < 2; g++)
            if (reset) begin
                sts[g] <= 1'b0;
                cnt[g] <= 0;
            end else if (tx_en[g] && !stub[g]) begin
                sts[g]   <= 1'b1;
                cnt[g]   <= 160;
                shreg[g] <= txd[g];
            end else if (cnt[g] > 0) begin
                cnt[g] <= cnt[g] - 1;
                sts[g] <= (cnt[g] > 1);
            end

    function automatic logic line_of(int g);
        int b;
        b = (160 - cnt[g]) / 16;
        if (!sts[g]) return 1'b1;
        return (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : shreg[g][b-1];
    endfunction

    typedef struct {int inst; logic [1:0] id; logic [7:0] data; int sp;} exp_t;
    exp_t q[$];
    exp_t mon_e;
    int compared = 0, mismatched = 0, cyc = 0;
    int last_en [2] = '{0, 0};

    always @(posedge BRclk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(int inst, int id, int data, int sp);
        exp_t e;
        e.inst = inst;
        e.id = 2'(id);
        e.data = 8'(data);
        e.sp = sp;
        q.push_back(e);
    endtask

    // Monitor: every load strobe pops the next expected launch and checks data, grant, ack and spacing
    always @(negedge BRclk)
        for (int g = 0; g < 2; g++)
            if (tx_en[g] === 1'b1) begin
                chk("no_load_while_busy", 32'(st_in[g]), 0);
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_launch: inst %0d data %0h", g, txd[g]);
                end else begin
                    mon_e = q.pop_front();
                    chk("launch_inst", g, mon_e.inst);
                    chk("tx_data", 32'(txd[g]), 32'(mon_e.data));
                    chk("grant_id", 32'(gid[g]), 32'(mon_e.id));
                    chk("ack_onehot", 32'(ack[g]), 32'(4'b0001 << mon_e.id));
                    if (mon_e.sp > 0) chk("tx_en_spacing", cyc - last_en[g], mon_e.sp);
                end
                last_en[g] = cyc;
            end else if (ack[g] !== 4'b0000) chk("ack_without_en", 32'(ack[g]), 0);

    task automatic wait_ack(int g, int b, output int t);
        int n = 0;
        do begin
            @(negedge BRclk);
            n++;
        end while (ack[g][b] !== 1'b1 && n < 400);
        chk("ack_seen", 32'(ack[g][b]), 1);
        t = cyc;
    endtask

    task automatic wait_cyc(int target);
        while (cyc < target) @(negedge BRclk);
    endtask

    task automatic wait_idle(int g);
        int n = 0;
        while (busy[g] !== 1'b0 && n < 400) begin
            @(negedge BRclk);
            n++;
        end
        chk("returns_idle", 32'(busy[g]), 0);
    endtask

    task automatic reset_pulse();
        @(negedge BRclk);
        reset = 1'b1;
        @(negedge BRclk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, n;
        logic [9:0] fr;
        for (int g = 0; g < 2; g++) begin
            req[g] = '0;
            din[g] = '0;
            clr[g] = 1'b0;
            stub[g] = 1'b0;
            force_busy[g] = 1'b0;
        end
        repeat (3) @(negedge BRclk);
        chk("rst_ack", 32'(ack[0]), 0);
        chk("rst_tx_en", 32'(tx_en[0]), 0);
        chk("rst_tx_data", 32'(txd[0]), 0);
        chk("rst_grant", 32'(gid[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_err", 32'(err[0]), 0);
        reset = 1'b0;

        @(negedge BRclk);
        din[0] = 32'h0000_00A5;
        req[0] = 4'b0001;
        push(0, 0, 8'hA5, 0);
        t0 = cyc;
        wait_ack(0, 0, t);
        req[0] = 4'b0000;
        chk("launch_latency", t - t0, 1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            wait_cyc(t + 9 + 16 * k);
            chk("serial_bit", 32'(line_of(0)), 32'(fr[k]));
        end
        wait_cyc(t + 161);
        chk("busy_at_frame_end", 32'(busy[0]), 1);
        wait_cyc(t + 162);
        chk("idle_after_frame", 32'(busy[0]), 0);

        reset_pulse();
        din[0] = 32'h1312_1110;
        req[0] = 4'b1111;
        push(0, 0, 8'h10, 0);
        push(0, 1, 8'h11, 163);
        push(0, 2, 8'h12, 163);
        push(0, 3, 8'h13, 163);
        push(0, 0, 8'h10, 163);
        for (int i = 0; i < 5; i++) wait_ack(0, i % 4, t);
        req[0] = 4'b0000;
        wait_idle(0);

        din[1] = 32'h0000_3231;
        req[1] = 4'b0011;
        push(1, 0, 8'h31, 0);
        push(1, 1, 8'h32, 183);
        wait_ack(1, 0, t);
        wait_ack(1, 1, t);
        req[1] = 4'b0000;
        wait_cyc(t + 165);
        chk("in_gap_wait", 32'(busy[1]), 1);
        din[1] = 32'h0033_0000;
        req[1] = 4'b0100;
        push(1, 2, 8'h33, 183);
        wait_ack(1, 2, t);
        req[1] = 4'b0000;
        wait_idle(1);

        stub[0] = 1'b1;
        din[0] = 32'h0000_0055;
        req[0] = 4'b0001;
        push(0, 0, 8'h55, 0);
        wait_ack(0, 0, t);
        req[0] = 4'b0000;
        wait_cyc(t + 4);
        chk("err_before_timeout", 32'(err[0]), 0);
        clr[0] = 1'b1;
        wait_cyc(t + 5);
        clr[0] = 1'b0;
        chk("err_set_wins", 32'(err[0]), 1);
        wait_cyc(t + 10);
        chk("err_sticky", 32'(err[0]), 1);
        chk("idle_after_timeout", 32'(busy[0]), 0);
        clr[0] = 1'b1;
        @(negedge BRclk);
        clr[0] = 1'b0;
        chk("err_cleared", 32'(err[0]), 0);
        stub[0] = 1'b0;
        din[0] = 32'h0000_6600;
        req[0] = 4'b0010;
        push(0, 1, 8'h66, 0);
        wait_ack(0, 1, t);
        req[0] = 4'b0000;
        wait_idle(0);

        din[0] = 32'h0000_7700;
        req[0] = 4'b0010;
        push(0, 1, 8'h77, 0);
        wait_ack(0, 1, t);
        req[0] = 4'b0000;
        wait_cyc(t + 50);
        reset = 1'b1;
        @(negedge BRclk);
        chk("midrst_ack", 32'(ack[0]), 0);
        chk("midrst_tx_en", 32'(tx_en[0]), 0);
        chk("midrst_tx_data", 32'(txd[0]), 0);
        chk("midrst_grant", 32'(gid[0]), 0);
        chk("midrst_busy", 32'(busy[0]), 0);
        reset = 1'b0;
        din[0] = 32'h0099_8800;
        req[0] = 4'b0110;
        push(0, 1, 8'h88, 0);
        wait_ack(0, 1, t);
        req[0] = 4'b0000;
        wait_idle(0);

        force_busy[0] = 1'b1;
        @(negedge BRclk);
        din[0] = 32'h0000_4400;
        req[0] = 4'b0010;
        @(negedge BRclk);
        req[0] = 4'b0000;
        n = 0;
        repeat (6) begin
            @(negedge BRclk);
            if (tx_en[0] !== 1'b0 || ack[0] !== 4'b0000) n++;
        end
        chk("no_launch_while_status", n, 0);
        chk("idle_while_status", 32'(busy[0]), 0);
        force_busy[0] = 1'b0;

        repeat (5) @(negedge BRclk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
